alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle controller between the keypad operand-capture stage and the display.
- Watches the capture stage's start strobe, latches operands a/b and an opcode, and runs the operation: 1-cycle add/sub, iterative shift-add multiply, optional restoring divide.
- Presents a held result with busy/done/error flags to the 7-segment/LED driver.
- Runs on the system 50 Hz clock.

Parameters:
- WIDTH, 4, operand width in bits (a, b).
- RES_W, 2*WIDTH, result width; must be at least 2*WIDTH.

Ports:
- clk_50HZ  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_alu  input  1  level from the capture stage; the operation triggers on its 0->1 transition.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- result  output  RES_W  operation result, held until the next accepted start.
- remainder  output  WIDTH  division remainder; 0 for other ops.
- busy  output  1  high from accept until done.
- done  output  1  one-cycle pulse when result becomes valid.
- err  output  1  sticky error flag (divide by zero, or div when compiled out); cleared on next accept.
- state_o  output  4  one-hot current state, for debug LEDs.

Behaviour:
- Reset (async, rst=1): state=IDLE (4'b0001), result=0, remainder=0, busy=0, done=0, err=0, start edge register=0, iteration counter=0.
- Start edge: start_q registers start_alu each cycle. Accept = start_alu & ~start_q & state==IDLE.
- A rise while not IDLE is ignored, not queued. Holding start_alu high does not retrigger.
- States, one-hot: IDLE=0001, EXEC=0010, ITER=0100, DONE=1000.
- IDLE, on accept:
  - latch a, b, op into internal registers;
  - clear err, result and remainder; busy=1;
  - go to EXEC.
- EXEC:
  - add: result = zero-extended a+b (carry kept at bit WIDTH); go to DONE.
  - sub: result = a-b as RES_W two's complement, sign-extended; go to DONE. Example: 3-5 gives 8'hFE.
  - mul: load multiplicand/multiplier; counter=WIDTH; go to ITER.
  - div, b==0: err=1, result=all ones, remainder=0; go to DONE.
  - div, b!=0: load restoring-divide registers; counter=WIDTH; go to ITER.
- ITER:
  - one shift-add (mul) or one shift-subtract-restore (div) step per cycle; counter decrements.
  - when counter reaches 1 and the step completes, write result/remainder and go to DONE.
  - ITER lasts exactly WIDTH cycles.
- DONE: done=1 for this cycle only; busy=0 on exit; go to IDLE.
- Latency, counted from the accept edge to the edge at which done becomes 1:
  - add/sub/div-by-zero: 2 cycles.
  - mul/div: WIDTH+2 cycles.
- busy is high in EXEC and ITER.
- Operand changes after accept have no effect until the next accept.
- result and remainder hold their values indefinitely in IDLE.
- Reset mid-operation aborts immediately to reset values, with no done pulse.
- The first rise of start_alu after reset is accepted normally. A start_alu already high when reset releases does not trigger (start_q resets to 0 but state needs a rise): start_q loads the sampled value in the first post-reset cycle and the accept qualifier is masked in that cycle.
- Widths: internal accumulator is RES_W+1 bits. No output truncation for WIDTH=4: max mul 15*15=225 fits in 8 bits.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined: division logic and remainder datapath are present as above.
- Undefined: op 11 goes EXEC->DONE with err=1, result=0, remainder=0 (latency 2); the divider registers are not synthesised; the remainder port stays tied 0.

Decomposition:
- Shared package alu_pkg:
  - state encodings (IDLE/EXEC/ITER/DONE one-hot);
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - default WIDTH.
- One natural sub-module: alu_iter_unit, the WIDTH-step shift-add/restoring-divide datapath.
  - Inputs: load, step, mode.
  - Outputs: result, remainder.
  - The FSM, edge detect, error and handshake stay in alu_op_sequencer.

Test Plan:
- Reset mid-mul: a=7, b=9, op=10, start rise; assert rst at ITER cycle 2 -> all outputs 0, state_o=0001, no done pulse; a fresh start then gives result=63.
- Add/sub: a=15, b=15, op=00, rise -> done at +2 cycles, result=8'd30. Then a=3, b=5, op=01 -> result=8'hFE, err=0.
- Mul: a=15, b=15, op=10 -> busy high for 5 cycles, done pulse at +6 cycles, result=8'd225; start_alu held high afterwards -> no second done.
- Div: a=14, b=4, op=11 (ALU_DIV_EN defined) -> result=3, remainder=2 at +6 cycles. With b=0 -> err=1, result=8'hFF at +2 cycles.
- Ignored start: a second rise of start_alu during ITER -> ignored; exactly one done pulse; operands changed during busy do not alter result.
- ALU_DIV_EN undefined: op=11, a=9, b=3 -> err=1, result=0, remainder=0, done at +2 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer and its iterative datapath.
// Holds the one-hot FSM state codes, the opcode values and the default operand width.
// Nothing here is clocked; it is imported by every other file of the block.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_EXEC = 4'b0010,
        S_ITER = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiply or restoring divide, one step per step_i cycle.
// Latency: WIDTH step cycles after load_i; outputs are final once the last step is taken.
// Backpressure: none, the controller owns load/step sequencing. Divide exists only with ALU_DIV_EN.
module alu_iter_unit #(
    parameter int WIDTH = 4,
    parameter int RES_W = 2 * WIDTH
) (
    input  logic               clk_50HZ,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               mode_i,      // 0: multiply, 1: divide
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [RES_W-1:0]   result_o
`ifdef ALU_DIV_EN
    ,
    output logic [WIDTH-1:0]   remainder_o
`endif
);

    // Accumulator layout: [2W:W] partial product / partial remainder, [W-1:0] multiplier / quotient.
    localparam int ACC_W = 2 * WIDTH + 1;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
    logic [ACC_W-1:0] div_sh;
    logic [WIDTH:0]   div_trial;
`endif

    // Next accumulator value: load the dividend/multiplier, or take one algorithm step
    always_comb begin
        mul_sum = acc_q[ACC_W-1:WIDTH] + {1'b0, opnd_q};
        acc_d   = acc_q;
`ifdef ALU_DIV_EN
        div_sh    = {acc_q[ACC_W-2:0], 1'b0};
        div_trial = div_sh[ACC_W-1:WIDTH];
`endif
        if (load_i) begin
            acc_d = {{(WIDTH + 1){1'b0}}, a_i};
`ifdef ALU_DIV_EN
        end else if (step_i && mode_i) begin
            // Shift in the next dividend bit; keep the subtraction only if it does not go negative
            if (div_trial >= {1'b0, opnd_q}) begin
                acc_d = {div_trial - {1'b0, opnd_q}, div_sh[WIDTH-1:1], 1'b1};
            end else begin
                acc_d = div_sh;
            end
`endif
        end else if (step_i && !mode_i) begin
            // Add the multiplicand when the current multiplier LSB is set, then shift right
            if (acc_q[0]) begin
                acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[ACC_W-1:1]};
            end
        end
    end

    // Accumulator and multiplicand/divisor registers
    always_ff @(posedge clk_50HZ or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (load_i) begin
                opnd_q <= b_i;
            end
        end
    end

`ifdef ALU_DIV_EN
    assign result_o    = mode_i ? RES_W'(acc_q[WIDTH-1:0]) : RES_W'(acc_q[2*WIDTH-1:0]);
    assign remainder_o = acc_q[2*WIDTH-1:WIDTH];
`else
    assign result_o    = RES_W'(acc_q[2*WIDTH-1:0]);
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: edge-triggered start, add/sub in one step, iterative mul/div, held result.
// Latency: accept to done pulse is 2 cycles for add/sub/error, WIDTH+2 for mul/div.
// Backpressure: none; a start rise outside IDLE is dropped. Divide built only with ALU_DIV_EN.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int RES_W = 2 * WIDTH
) (
    input  logic               clk_50HZ,
    input  logic               rst,
    input  logic               start_alu,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         op,
    output logic [RES_W-1:0]   result,
    output logic [WIDTH-1:0]   remainder,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [3:0]         state_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q;
    logic               start_q;
    logic               armed_q;     // low for the first cycle after reset so a held start cannot fire
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               iter_q;      // current op finishes through the iterative datapath
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [1:0]         op_q;
    logic [RES_W-1:0]   result_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;
    logic [RES_W-1:0]   iter_result;
`ifdef ALU_DIV_EN
    logic [WIDTH-1:0]   remainder_q;
    logic [WIDTH-1:0]   iter_remainder;
`endif

    assign accept = armed_q & start_alu & ~start_q & (state_q == S_IDLE);

    alu_iter_unit #(
        .WIDTH (WIDTH),
        .RES_W (RES_W)
    ) u_iter (
        .clk_50HZ    (clk_50HZ),
        .rst         (rst),
        .load_i      (state_q == S_EXEC),
        .step_i      (state_q == S_ITER),
        .mode_i      (op_q == OP_DIV),
        .a_i         (a_q),
        .b_i         (b_q),
        .result_o    (iter_result)
`ifdef ALU_DIV_EN
        ,
        .remainder_o (iter_remainder)
`endif
    );

    // Control FSM with registered result, flags and start-edge detection
    always_ff @(posedge clk_50HZ or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            armed_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            iter_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            result_q <= '0;
            cnt_q    <= '0;
`ifdef ALU_DIV_EN
            remainder_q <= '0;
`endif
        end else begin
            start_q <= start_alu;
            armed_q <= 1'b1;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        err_q    <= 1'b0;
                        iter_q   <= 1'b0;
                        result_q <= '0;
`ifdef ALU_DIV_EN
                        remainder_q <= '0;
`endif
                        busy_q   <= 1'b1;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_ADD: begin
                            result_q <= RES_W'(a_q) + RES_W'(b_q);
                            busy_q   <= 1'b0;
                            state_q  <= S_DONE;
                        end
                        OP_SUB: begin
                            result_q <= RES_W'(a_q) - RES_W'(b_q);
                            busy_q   <= 1'b0;
                            state_q  <= S_DONE;
                        end
                        OP_MUL: begin
                            cnt_q   <= CNT_W'(WIDTH);
                            iter_q  <= 1'b1;
                            state_q <= S_ITER;
                        end
                        OP_DIV: begin
`ifdef ALU_DIV_EN
                            if (b_q == '0) begin
                                err_q       <= 1'b1;
                                result_q    <= '1;
                                remainder_q <= '0;
                                busy_q      <= 1'b0;
                                state_q     <= S_DONE;
                            end else begin
                                cnt_q   <= CNT_W'(WIDTH);
                                iter_q  <= 1'b1;
                                state_q <= S_ITER;
                            end
`else
                            err_q    <= 1'b1;
                            result_q <= '0;
                            busy_q   <= 1'b0;
                            state_q  <= S_DONE;
`endif
                        end
                    endcase
                end
                S_ITER: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // The datapath has taken its final step; publish together with the done pulse
                    if (iter_q) begin
                        result_q <= iter_result;
                    end
`ifdef ALU_DIV_EN
                    if (iter_q && (op_q == OP_DIV)) begin
                        remainder_q <= iter_remainder;
                    end
`endif
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign result  = result_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign state_o = state_q;
`ifdef ALU_DIV_EN
    assign remainder = remainder_q;
`else
    assign remainder = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed plan steps plus randomized operations.
// Expected values come from plain integer arithmetic on the operands.
// Honours ALU_DIV_EN the same way the design does.
module tb_alu_op_sequencer;

    localparam int W  = 4;
    localparam int RW = 2 * W;

    logic          clk_50HZ  = 1'b0;
    logic          rst       = 1'b0;
    logic          start_alu = 1'b0;
    logic [W-1:0]  a         = '0;
    logic [W-1:0]  b         = '0;
    logic [1:0]    op        = '0;
    logic [RW-1:0] result;
    logic [W-1:0]  remainder;
    logic          busy;
    logic          done;
    logic          err;
    logic [3:0]    state_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_50HZ = ~clk_50HZ;

    alu_op_sequencer #(
        .WIDTH (W),
        .RES_W (RW)
    ) dut (
        .clk_50HZ  (clk_50HZ),
        .rst       (rst),
        .start_alu (start_alu),
        .a         (a),
        .b         (b),
        .op        (op),
        .result    (result),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_o   (state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the operation definitions
    task automatic model(input int ia, input int ib, input int iop,
                         output int eres, output int erem, output int eerr,
                         output int elat, output int ebusy);
        eres = 0; erem = 0; eerr = 0; elat = 2; ebusy = 1;
        case (iop)
            0: eres = ia + ib;
            1: eres = (ia - ib) & ((1 << RW) - 1);
            2: begin eres = ia * ib; elat = W + 2; ebusy = W + 1; end
            default: begin
`ifdef ALU_DIV_EN
                if (ib == 0) begin
                    eerr = 1; eres = (1 << RW) - 1;
                end else begin
                    eres = ia / ib; erem = ia % ib; elat = W + 2; ebusy = W + 1;
                end
`else
                eerr = 1;
`endif
            end
        endcase
    endtask

    // One operation: start rise, scramble operands while busy, optional extra rise, checks
    task automatic do_op(input int ia, input int ib, input int iop,
                         input bit hold, input bit poke, input string tag);
        int eres, erem, eerr, elat, ebusy;
        int n, busy_n, lat, extra;
        model(ia, ib, iop, eres, erem, eerr, elat, ebusy);
        @(negedge clk_50HZ); start_alu = 1'b0;
        @(negedge clk_50HZ);
        a = W'(ia); b = W'(ib); op = 2'(iop); start_alu = 1'b1;
        @(posedge clk_50HZ); #1;
        a = W'($urandom); b = W'($urandom); op = 2'($urandom_range(0, 3));
        busy_n = 0; lat = 0; n = 0;
        while (n < 30) begin
            if (busy) busy_n++;
            if (done) begin lat = n; break; end
            if (poke && n == 2) start_alu = 1'b0;
            if (poke && n == 3) start_alu = 1'b1;
            @(posedge clk_50HZ); #1; n++;
        end
        check($sformatf("%s.latency", tag), 32'(lat), 32'(elat));
        check($sformatf("%s.busy_cycles", tag), 32'(busy_n), 32'(ebusy));
        check($sformatf("%s.result", tag), 32'(result), 32'(eres));
        check($sformatf("%s.remainder", tag), 32'(remainder), 32'(erem));
        check($sformatf("%s.err", tag), 32'(err), 32'(eerr));
        check($sformatf("%s.state_idle", tag), 32'(state_o), 32'h1);
        @(posedge clk_50HZ); #1;
        check($sformatf("%s.done_pulse_end", tag), 32'(done), 32'h0);
        check($sformatf("%s.result_held", tag), 32'(result), 32'(eres));
        if (hold || poke) begin
            extra = 0;
            repeat (8) begin
                @(posedge clk_50HZ); #1;
                if (done || busy) extra++;
            end
            check($sformatf("%s.no_retrigger", tag), 32'(extra), 32'h0);
        end
        start_alu = 1'b0;
    endtask

    initial begin
        int dn;
        // Reset state
        #2 rst = 1'b1;
        #1;
        check("reset.state", 32'(state_o), 32'h1);
        check("reset.result", 32'(result), 32'h0);
        check("reset.remainder", 32'(remainder), 32'h0);
        check("reset.busy", 32'(busy), 32'h0);
        check("reset.done", 32'(done), 32'h0);
        check("reset.err", 32'(err), 32'h0);
        @(negedge clk_50HZ); @(negedge clk_50HZ); rst = 1'b0;

        // Reset in the middle of a multiply
        @(negedge clk_50HZ);
        a = 4'd7; b = 4'd9; op = 2'b10; start_alu = 1'b1;
        @(posedge clk_50HZ); #1;
        @(posedge clk_50HZ); #1;
        @(posedge clk_50HZ); #1;
        check("midrst.in_iter", 32'(state_o), 32'h4);
        rst = 1'b1; #1;
        check("midrst.state", 32'(state_o), 32'h1);
        check("midrst.result", 32'(result), 32'h0);
        check("midrst.busy", 32'(busy), 32'h0);
        check("midrst.done", 32'(done), 32'h0);
        check("midrst.err", 32'(err), 32'h0);
        @(negedge clk_50HZ); @(negedge clk_50HZ); rst = 1'b0;
        // start_alu still high across release: must not trigger
        dn = 0;
        repeat (6) begin
            @(posedge clk_50HZ); #1;
            if (done || busy) dn++;
        end
        check("midrst.held_start_ignored", 32'(dn), 32'h0);
        do_op(7, 9, 2, 1'b0, 1'b0, "fresh_mul");

        // Directed plan steps
        do_op(15, 15, 0, 1'b0, 1'b0, "add_15_15");
        do_op(3, 5, 1, 1'b0, 1'b0, "sub_3_5");
        do_op(15, 15, 2, 1'b1, 1'b0, "mul_15_15_hold");
        do_op(14, 4, 3, 1'b0, 1'b0, "div_14_4");
        do_op(9, 0, 3, 1'b0, 1'b0, "div_by_zero");
        do_op(2, 2, 0, 1'b0, 1'b0, "add_clears_err");
        do_op(9, 3, 3, 1'b0, 1'b0, "div_9_3");
        do_op(11, 13, 2, 1'b0, 1'b1, "mul_poke");
        do_op(0, 15, 1, 1'b0, 1'b0, "sub_0_15");

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), 1'b0, (i % 7) == 3, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
